// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI4-Lite register slave: response codes,
// default interface widths and a small index-width helper.
package axi_lite_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int STRB_W_DEF   = DATA_W_DEF / 8;
  localparam int RESP_W_DEF   = 2;
  localparam int PROT_W_DEF   = 3;
  localparam int NUM_REGS_DEF = 16;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // A single-register file still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_reg_file.sv
// Flop-based register file with per-byte write strobes, one asynchronous
// read port and the full contents exposed as a flat vector.
module axi_lite_reg_file
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int STRB_W     = STRB_W_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [STRB_W-1:0]              wstrb_i,
  input  logic [IDX_W-1:0]               ridx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;

  // NOTE: these are discrete flops with a defined reset value, so the whole
  // array is cleared on reset; a RAM macro could not be reset this way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wstrb_i[k]) begin
          mem_q[widx_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];
  assign regs_o  = mem_q;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS word registers. AW and W are captured
// independently; reads and writes run concurrently with registered outputs.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = ADDR_W_DEF,
  parameter int                    DATA_WIDTH      = DATA_W_DEF,
  parameter int                    TRANS_W_STRB_W  = STRB_W_DEF,
  parameter int                    TRANS_WR_RESP_W = RESP_W_DEF,
  parameter int                    TRANS_PROT      = PROT_W_DEF,
  parameter int                    NUM_REGS        = NUM_REGS_DEF,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                           m_axi_aclk_i,
  input  logic                           m_axi_aresetn_i,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr_i,
  input  logic [TRANS_PROT-1:0]          s_axi_awprot_i,
  input  logic                           s_axi_awvalid_i,
  output logic                           s_axi_awready_o,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata_i,
  input  logic [TRANS_W_STRB_W-1:0]      s_axi_wstrb_i,
  input  logic                           s_axi_wvalid_i,
  output logic                           s_axi_wready_o,
  output logic [TRANS_WR_RESP_W-1:0]     s_axi_bresp_o,
  output logic                           s_axi_bvalid_o,
  input  logic                           s_axi_bready_i,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr_i,
  input  logic [TRANS_PROT-1:0]          s_axi_arprot_i,
  input  logic                           s_axi_arvalid_i,
  output logic                           s_axi_arready_o,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata_o,
  output logic [TRANS_WR_RESP_W-1:0]     s_axi_rresp_o,
  output logic                           s_axi_rvalid_o,
  input  logic                           s_axi_rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = idx_width(NUM_REGS);
  localparam int WRD_W = ADDR_WIDTH - 2;

  localparam logic [TRANS_WR_RESP_W-1:0] OKAY   = TRANS_WR_RESP_W'(RESP_OKAY);
  localparam logic [TRANS_WR_RESP_W-1:0] SLVERR = TRANS_WR_RESP_W'(RESP_SLVERR);

  typedef struct packed {
    logic             in_range;
    logic [IDX_W-1:0] idx;
  } decode_t;

  // Addresses below BASE_ADDR wrap to a huge word index and fall out of range.
  function automatic decode_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    logic [WRD_W-1:0]      word;
    decode_t               d;
    offset     = addr - BASE_ADDR;
    word       = WRD_W'(offset >> 2);
    d.in_range = (word < WRD_W'(NUM_REGS));
    d.idx      = word[IDX_W-1:0];
    return d;
  endfunction

  logic                       awready_q, awready_d;
  logic                       wready_q,  wready_d;
  logic                       arready_q, arready_d;
  logic                       aw_held_q, aw_held_d;
  logic                       w_held_q,  w_held_d;
  logic [ADDR_WIDTH-1:0]      awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q,   wdata_d;
  logic [TRANS_W_STRB_W-1:0]  wstrb_q,   wstrb_d;
  logic                       bvalid_q,  bvalid_d;
  logic [TRANS_WR_RESP_W-1:0] bresp_q,   bresp_d;
  logic                       rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0]      rdata_q,   rdata_d;
  logic [TRANS_WR_RESP_W-1:0] rresp_q,   rresp_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  commit, rf_we;
  decode_t               wr_dec, rd_dec;
  logic [DATA_WIDTH-1:0] rf_rdata;

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};

  assign aw_hs  = s_axi_awvalid_i & awready_q;
  assign w_hs   = s_axi_wvalid_i  & wready_q;
  assign b_hs   = bvalid_q        & s_axi_bready_i;
  assign ar_hs  = s_axi_arvalid_i & arready_q;
  assign r_hs   = rvalid_q        & s_axi_rready_i;

  assign wr_dec = decode(awaddr_q);
  assign rd_dec = decode(s_axi_araddr_i);
  assign commit = aw_held_q & w_held_q;
  assign rf_we  = commit & wr_dec.in_range;

  // NOTE: every variable gets its hold value first, so no path through the
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata_i;
      wstrb_d  = s_axi_wstrb_i;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_dec.in_range ? OKAY : SLVERR;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d  && !bvalid_d;
  end

  // The register file is read before this edge's write lands, so a read
  // colliding with a commit returns the pre-write value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_dec.in_range ? rf_rdata : '0;
      rresp_d  = rd_dec.in_range ? OKAY : SLVERR;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end

    arready_d = !rvalid_d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
    if (!m_axi_aresetn_i) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_lite_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_W     (TRANS_W_STRB_W),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_reg_file (
    .clk_i   (m_axi_aclk_i),
    .rst_ni  (m_axi_aresetn_i),
    .we_i    (rf_we),
    .widx_i  (wr_dec.idx),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .ridx_i  (rd_dec.idx),
    .rdata_o (rf_rdata),
    .regs_o  (regs_o)
  );

  assign s_axi_awready_o = awready_q;
  assign s_axi_wready_o  = wready_q;
  assign s_axi_arready_o = arready_q;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: inputs change and outputs are
// sampled on the falling clock edge, expected values are hand-computed.
module tb_axi_lite_slave_regs;

  logic         clk;
  logic         rst_n;
  logic [31:0]  awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] regs;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] exp_regs [16];

  axi_lite_slave_regs dut (
    .m_axi_aclk_i    (clk),
    .m_axi_aresetn_i (rst_n),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awprot_i  (awprot),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bresp_o   (bresp),
    .s_axi_bvalid_o  (bvalid),
    .s_axi_bready_i  (bready),
    .s_axi_araddr_i  (araddr),
    .s_axi_arprot_i  (arprot),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rdata_o   (rdata),
    .s_axi_rresp_o   (rresp),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rready_i  (rready),
    .regs_o          (regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Single write with AW and W together, bready high; called with readies up.
  task automatic write_simple(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] exp_resp);
    bready  = 1'b1;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    cyc();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check({tag, "_bvalid_before_commit"}, 32'(bvalid), 32'd0);
    check({tag, "_awready_low"}, 32'(awready), 32'd0);
    cyc();
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    cyc();
    check({tag, "_bvalid_cleared"}, 32'(bvalid), 32'd0);
    check({tag, "_awready_back"}, 32'(awready), 32'd1);
    check({tag, "_wready_back"}, 32'(wready), 32'd1);
  endtask

  task automatic read_simple(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
    rready  = 1'b1;
    araddr  = addr;
    arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
    check({tag, "_arready_low"}, 32'(arready), 32'd0);
    cyc();
    check({tag, "_rvalid_cleared"}, 32'(rvalid), 32'd0);
    check({tag, "_arready_back"}, 32'(arready), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    awaddr  = '0;
    awprot  = 3'b010;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arprot  = 3'b101;
    arvalid = 1'b0;
    rready  = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;

    // Reset state and first edge after release.
    cyc();
    cyc();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_regs_lo", regs[31:0], 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // Full-word write to register 1.
    write_simple("w_full", 32'h0000_0004, 32'hDEAD_BEEF, 4'b1111, 2'b00);
    check("w_full_reg1", regs[63:32], 32'hDEAD_BEEF);

    // Low-half strobe write, then read back; low address bits are ignored.
    write_simple("w_strb", 32'h0000_0004, 32'h0000_0000, 4'b0011, 2'b00);
    check("w_strb_reg1", regs[63:32], 32'hDEAD_0000);
    exp_regs[1] = 32'hDEAD_0000;
    read_simple("r_reg1", 32'h0000_0004, 32'hDEAD_0000, 2'b00);
    read_simple("r_reg1_unaligned", 32'h0000_0007, 32'hDEAD_0000, 2'b00);

    // W three cycles ahead of AW, then B back-pressured for four cycles.
    bready = 1'b0;
    wdata  = 32'h1234_5678;
    wstrb  = 4'b1111;
    wvalid = 1'b1;
    cyc();
    wvalid = 1'b0;
    check("wfirst_wready_low", 32'(wready), 32'd0);
    check("wfirst_awready_high", 32'(awready), 32'd1);
    cyc();
    cyc();
    awaddr  = 32'h0000_000C;
    awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
    check("wfirst_awready_low", 32'(awready), 32'd0);
    check("wfirst_bvalid_early", 32'(bvalid), 32'd0);
    cyc();
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_reg3", regs[127:96], 32'h1234_5678);
    exp_regs[3] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bhold_bvalid", 32'(bvalid), 32'd1);
      check("bhold_bresp", 32'(bresp), 32'd0);
      check("bhold_awready", 32'(awready), 32'd0);
      check("bhold_wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    cyc();
    check("bhold_bvalid_cleared", 32'(bvalid), 32'd0);
    check("bhold_awready_back", 32'(awready), 32'd1);
    check("bhold_wready_back", 32'(wready), 32'd1);

    // Last register, top byte only.
    write_simple("w_last", 32'h0000_003C, 32'hAABB_CCDD, 4'b1000, 2'b00);
    exp_regs[15] = 32'hAA00_0000;
    read_simple("r_last", 32'h0000_003C, 32'hAA00_0000, 2'b00);

    // First address past the register file.
    write_simple("w_oor", 32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 2'b10);
    for (int i = 0; i < 16; i++) check("w_oor_regs", regs[i*32 +: 32], exp_regs[i]);
    read_simple("r_oor", 32'h0000_0040, 32'h0000_0000, 2'b10);

    // Write commit and AR handshake on the same edge, same register.
    write_simple("w_reg2", 32'h0000_0008, 32'hCAFE_1234, 4'b1111, 2'b00);
    rready  = 1'b0;
    awaddr  = 32'h0000_0008;
    wdata   = 32'h1111_1111;
    wstrb   = 4'b1111;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    cyc();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 32'h0000_0008;
    arvalid = 1'b1;
    check("coll_arready", 32'(arready), 32'd1);
    cyc();
    arvalid = 1'b0;
    check("coll_bvalid", 32'(bvalid), 32'd1);
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_rdata_old", rdata, 32'hCAFE_1234);
    check("coll_reg2_new", regs[95:64], 32'h1111_1111);
    cyc();
    check("coll_rvalid_hold", 32'(rvalid), 32'd1);
    check("coll_rdata_hold", rdata, 32'hCAFE_1234);
    rready = 1'b1;
    cyc();
    check("coll_rvalid_cleared", 32'(rvalid), 32'd0);
    read_simple("r_reg2_new", 32'h0000_0008, 32'h1111_1111, 2'b00);

    // Reset while a write response is pending.
    bready  = 1'b0;
    awaddr  = 32'h0000_0014;
    wdata   = 32'h5555_5555;
    wstrb   = 4'b1111;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    cyc();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    cyc();
    check("mid_bvalid_pending", 32'(bvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_bresp", 32'(bresp), 32'd0);
    check("mid_rst_awready", 32'(awready), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    for (int i = 0; i < 16; i++) check("mid_rst_regs", regs[i*32 +: 32], 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    check("mid_rel_awready_pre", 32'(awready), 32'd0);
    cyc();
    check("mid_rel_awready", 32'(awready), 32'd1);
    check("mid_rel_wready", 32'(wready), 32'd1);
    check("mid_rel_arready", 32'(arready), 32'd1);
    check("mid_rel_bvalid", 32'(bvalid), 32'd0);
    cyc();
    check("mid_rel_no_resp", 32'(bvalid), 32'd0);
    check("mid_rel_reg5", regs[191:160], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width.
REQ-003 Parameter TRANS_W_STRB_W, default 4, write-strobe width (DATA_WIDTH/8).
REQ-004 Parameter TRANS_WR_RESP_W, default 2, response width.
REQ-005 Parameter TRANS_PROT, default 3, prot width.
REQ-006 Parameter NUM_REGS, default 16, number of 32-bit registers.
REQ-007 Parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0.
REQ-008 m_axi_aclk_i  in  1  single clock; all logic rising-edge.
REQ-009 m_axi_aresetn_i  in  1  reset, asynchronous, active-low.
REQ-010 s_axi_awaddr_i in ADDR_WIDTH; s_axi_awprot_i in TRANS_PROT; s_axi_awvalid_i in 1; s_axi_awready_o out 1  AW channel.
REQ-011 s_axi_wdata_i in DATA_WIDTH; s_axi_wstrb_i in TRANS_W_STRB_W; s_axi_wvalid_i in 1; s_axi_wready_o out 1  W channel.
REQ-012 s_axi_bresp_o out TRANS_WR_RESP_W; s_axi_bvalid_o out 1; s_axi_bready_i in 1  B channel.
REQ-013 s_axi_araddr_i in ADDR_WIDTH; s_axi_arprot_i in TRANS_PROT; s_axi_arvalid_i in 1; s_axi_arready_o out 1  AR channel.
REQ-014 s_axi_rdata_o out DATA_WIDTH; s_axi_rresp_o out TRANS_WR_RESP_W; s_axi_rvalid_o out 1; s_axi_rready_i in 1  R channel.
REQ-015 regs_o  out  NUM_REGS*DATA_WIDTH  current register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-016 A handshake SHALL complete on a rising edge where valid and ready are both high; all outputs SHALL be registered.
REQ-017 The write path SHALL capture AW and W independently: awready_o high while no AW held and no B pending; wready_o high while no W held and no B pending; each drops the cycle after its handshake.
REQ-018 The cycle after both AW and W are held, the write SHALL commit and bvalid_o SHALL assert (write latency: 1 cycle after the later of the two handshakes).
REQ-019 Register index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; index < NUM_REGS is in range.
REQ-020 In-range write SHALL update byte lane k only where wstrb[k]=1 and return bresp 2'b00 (OKAY); out-of-range write SHALL change nothing and return 2'b10 (SLVERR).
REQ-021 bvalid_o and bresp_o SHALL hold stable until bready_i handshake; awready_o/wready_o re-assert the cycle after.
REQ-022 AW and W handshakes in the same cycle SHALL be legal; W before AW SHALL be legal.
REQ-023 arready_o SHALL be high while no R pending; the cycle after an AR handshake rvalid_o SHALL assert with rdata/rresp (read latency 1).
REQ-024 In-range read SHALL return the register value with rresp 2'b00; out-of-range SHALL return rdata 0, rresp 2'b10.
REQ-025 rvalid_o, rdata_o, rresp_o SHALL hold stable until rready_i handshake; arready_o re-asserts the cycle after.
REQ-026 Read and write paths SHALL be fully concurrent; if a write commits in the AR handshake cycle to the same register, rdata SHALL return the pre-write value.
REQ-027 awprot/arprot SHALL be accepted and ignored.

Reset
REQ-028 On m_axi_aresetn_i low, immediately: all registers 0; held AW/W discarded; bvalid_o, rvalid_o 0; bresp_o, rresp_o, rdata_o 0; awready_o, wready_o, arready_o 0.
REQ-029 The first rising edge after reset release SHALL set awready_o, wready_o, arready_o to 1; reset mid-transaction SHALL drop the transaction with no response issued.

Structure
REQ-030 Shared package axi_lite_pkg SHALL hold RESP_OKAY 2'b00, RESP_SLVERR 2'b10, and default width constants.
REQ-031 Storage with byte-strobe write SHALL be sub-module axi_lite_reg_file; handshake/decode control stays in the top.

Verification
REQ-032 Write 0x0000_0004 data DEADBEEF strb 1111, bready high -> bresp 00 one cycle after AW/W; regs_o[63:32]=DEADBEEF.
REQ-033 Write reg 1 data 0000_0000 strb 0011 -> reg 1 = DEAD0000; read 0x4 -> rdata DEAD0000, rresp 00, rvalid one cycle after AR.
REQ-034 W handshake 3 cycles before AW, bready low 4 cycles -> bvalid held with stable bresp; awready/wready stay low until bready.
REQ-035 Write/read 0x0000_0040 (NUM_REGS=16) -> bresp 10, no register change; rdata 0, rresp 10.
REQ-036 Same-cycle write commit to reg 2 (11111111) and AR of 0x8 (old CAFE1234) -> rdata CAFE1234; next read 11111111.
REQ-037 Reset asserted with bvalid pending -> bvalid 0 immediately, all regs 0, readies 1 on first edge after release.
